serial_frame_controller: RTL
============================

# serial_frame_controller

Sequencing controller for the serial-in/parallel-out capture path. It arms on a frame-start strobe, counts exactly WIDTH qualified serial bits into an internal shifter, then presents the assembled word on a valid/ready output port. Lost words are flagged with a sticky overrun bit. It sits between the serial bit source and the parallel consumer, replacing free-running shifting with framed, counted captures.

## Interface
- WIDTH, 8: bits per frame and output word width; must be at least 2.
- clk, input, 1: single clock; all logic updates on the rising edge.
- reset, input, 1: synchronous, active-low; 0 at a rising edge resets all state.
- data, input, 1: serial bit; sampled only when bit_valid=1 in SHIFT.
- bit_valid, input, 1: qualifies data for one cycle.
- frame_start, input, 1: single-cycle strobe that begins or restarts a frame.
- byte_ready, input, 1: consumer accepts byte_out when byte_valid=1.
- byte_out, output, WIDTH: assembled word; MSB is the first bit received.
- byte_valid, output, 1: byte_out holds an unaccepted word.
- busy, output, 1: state is SHIFT or LOAD.
- bit_count, output, clog2(WIDTH+1): number of bits captured in the current frame.
- overrun, output, 1: sticky; a completed frame was dropped.

## Operation
- Reset values:
  - state = IDLE.
  - byte_out = 0, byte_valid = 0, busy = 0, bit_count = 0, overrun = 0.
  - Shifter = 0.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - frame_start=1 → SHIFT; shifter cleared; bit_count = 0.
  - bit_valid is ignored in IDLE.
- SHIFT:
  - On each bit_valid=1: shifter = {shifter[WIDTH-2:0], data}; bit_count increments.
  - When the WIDTH-th bit is taken (bit_count == WIDTH-1 with bit_valid=1) → LOAD.
  - bit_valid=0 holds all state; there is no timeout.
- Frame restart: frame_start=1 in SHIFT or LOAD clears the shifter, sets bit_count = 0, and enters SHIFT. The strobe cycle never shifts, even if bit_valid=1 in the same cycle.
- LOAD (one cycle): transfers the shifter to the output port, then → IDLE and bit_count = 0.
  - If the output slot is free (byte_valid=0, or byte_valid=1 with byte_ready=1): byte_out = shifter; byte_valid = 1.
  - Otherwise: the new word is dropped, byte_out keeps the old word, and overrun is set to 1.
- Output handshake: a transfer occurs on a cycle where byte_valid=1 and byte_ready=1. That edge clears byte_valid unless LOAD reloads it in the same cycle. byte_out is stable while byte_valid=1.
- overrun is cleared only by reset.

## Timing
- Last bit sampled at edge N (state → LOAD).
- byte_out and byte_valid are updated at edge N+1, giving a latency of 1 cycle after the last bit.
- Minimum frame length is WIDTH+2 cycles: 1 strobe cycle, WIDTH bit cycles, 1 LOAD cycle.
- Back-to-back frames are allowed: frame_start may arrive in the cycle after LOAD.
- busy:
  - rises at the edge that samples frame_start;
  - falls at edge N+1.
- bit_count reads WIDTH in the LOAD cycle.
- Reset is dominant over every other input in the same cycle. Reset mid-frame discards the partial word and any pending byte_valid.

## Structure
- Shared package `serial_ctrl_pkg` holds:
  - FSM state enum `sfc_state_t` (IDLE, SHIFT, LOAD);
  - default width constant `SFC_WIDTH = 8`.
- Sub-module `serial_shifter`: WIDTH-bit left shifter with enable, synchronous clear, and synchronous active-low reset.
- The FSM, counter, output register and overrun flag live in the top module.

## Test plan
- Basic frame: reset, frame_start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles with byte_ready=1 → byte_out=8'hA5, byte_valid high exactly 1 cycle, busy low afterwards, overrun=0.
- Gapped bits: the same frame with bit_valid deasserted 3 cycles between each bit → byte_out=8'hA5; bit_count steps 0..8 only on valid cycles.
- Backpressure and overrun:
  - First frame 8'h3C with byte_ready=0 → byte_valid held and byte_out=8'h3C.
  - Second frame 8'hC3 → byte_out stays 8'h3C, overrun=1.
  - Raise byte_ready → byte_valid drops next edge; overrun stays 1.
- Simultaneous accept and load: byte_valid=1 (8'h11) and byte_ready=1 in the LOAD cycle of frame 8'h22 → byte_out=8'h22, byte_valid stays 1, overrun=0.
- Restart: frame_start after 5 bits, then 8 bits of 8'hF0 → byte_out=8'hF0. Also frame_start with bit_valid=1 in the same cycle → that bit is not counted.
- Reset mid-frame: reset=0 after 4 bits → all outputs return to 0 and the next full frame 8'h81 captures correctly.

Source files
------------

// File: rtl/serial_ctrl_pkg.sv
// ============================================================================
// Module   : serial_ctrl_pkg
// Brief    : Shared FSM state type and default width for the serial frame path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_ctrl_pkg;

    localparam int SFC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } sfc_state_t;

endpackage : serial_ctrl_pkg

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
// Module   : serial_shifter
// Brief    : WIDTH-bit left shifter with enable and synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Clear wins over enable so a restart strobe never shifts a bit in.
    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (en_i) begin
            word_d = {word_q[WIDTH-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule : serial_shifter

`default_nettype wire

// File: rtl/serial_frame_controller.sv
// ============================================================================
// Module   : serial_frame_controller
// Brief    : Framed serial-to-parallel capture with valid/ready output and overrun flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_frame_controller
    import serial_ctrl_pkg::*;
#(
    parameter int WIDTH = SFC_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data,
    input  logic                       bit_valid,
    input  logic                       frame_start,
    input  logic                       byte_ready,
    output logic [WIDTH-1:0]           byte_out,
    output logic                       byte_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int                 CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   c_LAST_BIT = CNT_W'(WIDTH - 1);

    sfc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             w_sh_clr;
    logic             w_sh_en;
    logic [WIDTH-1:0] w_sh_word;

    serial_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (w_sh_clr),
        .en_i   (w_sh_en),
        .bit_i  (data),
        .word_o (w_sh_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q & ~byte_ready;
        ovr_d    = ovr_q;
        w_sh_clr = 1'b0;
        w_sh_en  = 1'b0;

        case (state_q)
            SHIFT: begin
                if (!frame_start && bit_valid) begin
                    w_sh_en = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == c_LAST_BIT) begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                // A completed word is delivered even if a restart arrives in this cycle.
                if (!valid_q || byte_ready) begin
                    out_d   = w_sh_word;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
            end
        endcase

        if (frame_start) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            w_sh_clr = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign byte_out   = out_q;
    assign byte_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign bit_count  = cnt_q;
    assign overrun    = ovr_q;

endmodule : serial_frame_controller

`default_nettype wire
